// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared sizes, sweep-result and debounce-state types for the keypad scanner.
// Revision : 1.0
// ============================================================================
package keypad_pkg;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;
  localparam int KEY_W  = 4;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } sweep_res_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSING  = 2'd1,
    ST_HELD      = 2'd2,
    ST_RELEASING = 2'd3
  } db_state_t;

  function automatic logic [2:0] low_count(input logic [N_ROWS-1:0] lows);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < N_ROWS; i++) begin
      n = n + {2'b00, lows[i]};
    end
    return n;
  endfunction

  function automatic logic [1:0] low_index(input logic [N_ROWS-1:0] lows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < N_ROWS; i++) begin
      if (lows[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner_if
// Brief    : Key-event handshake between the scanner (master) and its consumer (slave).
// Revision : 1.0
// ============================================================================
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ack;
  logic             overrun;

  modport master (output key_code, output key_valid, output overrun, input key_ack);
  modport slave  (input key_code, input key_valid, input overrun, output key_ack);

endinterface
`default_nettype wire

// File: rtl/keypad_scanner_col_driver.sv
`default_nettype none
// ============================================================================
// Module   : keypad_col_driver
// Brief    : Column strobing, row synchronizer and per-sweep NONE/SINGLE/MULTI result.
// Revision : 1.0
// ============================================================================
module keypad_col_driver
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_ROWS-1:0] row_i,
  output logic [N_COLS-1:0] col_o,
  output logic              sweep_done_o,
  output sweep_res_t        result_o,
  output logic [KEY_W-1:0]  code_o
);

  localparam int            DW         = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);

  logic [N_ROWS-1:0] row_meta_q, row_sync_q;
  logic [DW-1:0]     dwell_q;
  logic [N_COLS-1:0] col_q;
  logic [1:0]        col_idx_q;
  logic [1:0]        hits_q, hits_d;   // 2 stands for "more than one"
  logic [KEY_W-1:0]  code_acc_q, code_acc_d;
  logic              sweep_done_q;
  sweep_res_t        result_q, result_d;
  logic [KEY_W-1:0]  code_q;

  logic              terminal;
  logic [N_ROWS-1:0] lows;
  logic [2:0]        col_hits;

  always_comb begin
    terminal   = (dwell_q == DWELL_LAST);
    lows       = ~row_sync_q;
    col_hits   = low_count(lows);
    hits_d     = hits_q;
    code_acc_d = code_acc_q;
    if ((col_hits > 3'd1) || ((col_hits == 3'd1) && (hits_q != 2'd0))) begin
      hits_d = 2'd2;
    end else if (col_hits == 3'd1) begin
      hits_d     = 2'd1;
      code_acc_d = {low_index(lows), col_idx_q};
    end
    case (hits_d)
      2'd0:    result_d = RES_NONE;
      2'd1:    result_d = RES_SINGLE;
      default: result_d = RES_MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Synchronizer clears to the pulled-up (no key) level
      row_meta_q   <= '1;
      row_sync_q   <= '1;
      dwell_q      <= '0;
      col_q        <= 4'b1110;
      col_idx_q    <= 2'd0;
      hits_q       <= 2'd0;
      code_acc_q   <= '0;
      sweep_done_q <= 1'b0;
      result_q     <= RES_NONE;
      code_q       <= '0;
    end else begin
      row_meta_q   <= row_i;
      row_sync_q   <= row_meta_q;
      sweep_done_q <= 1'b0;
      if (terminal) begin
        dwell_q   <= '0;
        col_q     <= {col_q[N_COLS-2:0], col_q[N_COLS-1]};
        col_idx_q <= col_idx_q + 2'd1;
        if (col_idx_q == 2'(N_COLS - 1)) begin
          sweep_done_q <= 1'b1;
          result_q     <= result_d;
          code_q       <= code_acc_d;
          hits_q       <= 2'd0;
          code_acc_q   <= '0;
        end else begin
          hits_q     <= hits_d;
          code_acc_q <= code_acc_d;
        end
      end else begin
        dwell_q <= dwell_q + 1'b1;
      end
    end
  end

  assign col_o        = col_q;
  assign sweep_done_o = sweep_done_q;
  assign result_o     = result_q;
  assign code_o       = code_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 keypad front end: sweep-level debounce and one key event per press.
// Revision : 1.0
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS   = 50000,
  parameter int STABLE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_ROWS-1:0] row_i,
  output logic [N_COLS-1:0] col_o,
  keypad_scanner_if.master  key_if
);

  localparam int            CW       = $clog2(STABLE_SCANS + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_SCANS);

  logic             sweep_done;
  sweep_res_t       result;
  logic [KEY_W-1:0] code;

  db_state_t        state_q;
  logic [CW-1:0]    cnt_q, cnt_inc;
  logic [KEY_W-1:0] cand_q, key_code_q;
  logic             key_valid_q, overrun_q;
  logic             same_single, accept;

  keypad_col_driver #(
    .SCAN_TICKS(SCAN_TICKS)
  ) u_col_driver (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_i       (row_i),
    .col_o       (col_o),
    .sweep_done_o(sweep_done),
    .result_o    (result),
    .code_o      (code)
  );

  always_comb begin
    same_single = (result == RES_SINGLE) && (code == cand_q);
    cnt_inc     = cnt_q + 1'b1;
    accept      = sweep_done && (state_q == ST_PRESSING) && same_single && (cnt_inc == CNT_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (key_valid_q && key_if.key_ack) begin
        key_valid_q <= 1'b0;
      end
      // An ack on the accept edge frees the slot for the new code
      if (accept) begin
        if (!key_valid_q || key_if.key_ack) begin
          key_code_q  <= cand_q;
          key_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
      if (sweep_done) begin
        case (state_q)
          ST_IDLE: begin
            if (result == RES_SINGLE) begin
              cand_q  <= code;
              cnt_q   <= CW'(1);
              state_q <= ST_PRESSING;
            end
          end
          ST_PRESSING: begin
            if (same_single) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == CNT_DONE) begin
                state_q <= ST_HELD;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (result == RES_NONE) begin
              cnt_q   <= CW'(1);
              state_q <= ST_RELEASING;
            end
          end
          ST_RELEASING: begin
            if (result == RES_NONE) begin
              if (cnt_inc == CNT_DONE) begin
                cnt_q   <= '0;
                state_q <= ST_IDLE;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= ST_HELD;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign key_if.key_code  = key_code_q;
  assign key_if.key_valid = key_valid_q;
  assign key_if.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Self-checking bench: keypad contact model plus sweep-level event model.
// Revision : 1.0
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN   = 4;
  localparam int STABLE = 2;
  localparam int SWEEP  = 4 * SCAN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row, col;
  logic [15:0] keys = '0;
  logic        bounce_en = 1'b0;
  logic [3:0]  bounce_val = 4'hF;
  logic        kack = 1'b0;

  int checks = 0;
  int errors = 0;

  // Sweep-level reference state
  bit         exact, auto_ack, have_prev;
  logic [15:0] prev_mask;
  bit         m_pending, m_held, m_ovr_now;
  int         m_run, m_rel;
  logic [3:0] m_cand, m_code;
  int         exp_q[$];
  int         exp_ovr;
  // Observed events
  int         obs_q[$];
  int         obs_ovr, cyc, first_valid_cyc;
  bit         prev_valid;

  keypad_scanner_if kif();
  assign kif.key_ack = kack;

  keypad_scanner #(
    .SCAN_TICKS  (SCAN),
    .STABLE_SCANS(STABLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .row_i (row),
    .col_o (col),
    .key_if(kif.master)
  );

  always #5 clk = ~clk;

  // Pressed key (r,c) pulls row r low while column c is strobed
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
    if (bounce_en) row = bounce_val;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_sweep(input logic [15:0] mask, output bit acc, output logic [3:0] acode);
    int n;
    logic [3:0] k;
    n = $countones(mask);
    k = 4'd0;
    for (int i = 0; i < 16; i++) if (mask[i]) k = 4'(i);
    acc   = 1'b0;
    acode = m_cand;
    if (!m_held) begin
      if (m_run == 0) begin
        if (n == 1) begin m_cand = k; m_run = 1; end
      end else if (n == 1 && k == m_cand) begin
        m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run == STABLE) begin
        acc = 1'b1; acode = m_cand; m_held = 1'b1; m_run = 0; m_rel = 0;
      end
    end else begin
      if (n == 0) m_rel++; else m_rel = 0;
      if (m_rel == STABLE) begin m_held = 1'b0; m_rel = 0; end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; kack = 1'b0; keys = '0; bounce_en = 1'b0; bounce_val = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", col, 4'b1110);
    chk("rst_valid", kif.key_valid, 1'b0);
    chk("rst_code", kif.key_code, 4'h0);
    chk("rst_ovr", kif.overrun, 1'b0);
    have_prev = 0; prev_mask = '0; m_pending = 0; m_held = 0; m_ovr_now = 0;
    m_run = 0; m_rel = 0; m_cand = 0; m_code = 0; exp_q.delete(); exp_ovr = 0;
    obs_q.delete(); obs_ovr = 0; cyc = 0; first_valid_cyc = -1; prev_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_sweep(input logic [15:0] mask, input bit ack_first, input bit bounce);
    bit         acc, ack_edge;
    logic [3:0] acode;
    keys = mask;
    for (int t = 0; t < SWEEP; t++) begin
      if (bounce) begin
        bounce_en  = 1'b1;
        bounce_val = (((t / 2) % 2) == 0) ? 4'b1110 : 4'b1111;
      end
      if (t == 0 && ack_first) kack = 1'b1;
      @(posedge clk);
      cyc++;
      ack_edge  = kack;
      acc       = 1'b0;
      acode     = 4'd0;
      m_ovr_now = 1'b0;
      if (t == 0 && have_prev && exact) model_sweep(prev_mask, acc, acode);
      if (acc) begin
        if (!m_pending || ack_edge) begin
          m_pending = 1'b1; m_code = acode; exp_q.push_back(int'(acode));
        end else begin
          m_ovr_now = 1'b1; exp_ovr++;
        end
      end else if (ack_edge) begin
        m_pending = 1'b0;
      end
      #1;
      if (kif.key_valid && (!prev_valid || ack_edge)) obs_q.push_back(int'(kif.key_code));
      if (kif.key_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (kif.overrun) obs_ovr++;
      prev_valid = kif.key_valid;
      if (exact && (t == 0 || t == 1 || t == 2 || t == 8)) begin
        chk("valid", kif.key_valid, m_pending);
        chk("overrun", kif.overrun, m_ovr_now);
        if (m_pending) chk("code", kif.key_code, m_code);
      end
      kack = auto_ack && (exact ? m_pending : kif.key_valid) && !kack;
    end
    bounce_en = 1'b0;
    prev_mask = mask;
    have_prev = 1'b1;
  endtask

  task automatic end_scenario(input string tag);
    chk({tag, "_nev"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk({tag, "_evcode"}, obs_q[i], exp_q[i]);
    chk({tag, "_novr"}, obs_ovr, exp_ovr);
  endtask

  initial begin
    logic [15:0] mask;
    int          run_left, kind, a, b, n;
    bit          af;

    // 1: reset and first rotation
    exact = 1; auto_ack = 1;
    do_reset();
    repeat (3) @(posedge clk);
    #1 chk("t1_col_before", col, 4'b1110);
    @(posedge clk);
    #1 chk("t1_col_rot", col, 4'b1101);

    // 2: single press (2,1), ack one cycle after valid
    do_reset();
    for (int k = 0; k < 4; k++) run_sweep(16'h0200, 0, 0);
    for (int k = 0; k < 3; k++) run_sweep(16'h0000, 0, 0);
    chk("t2_latency_ok", (first_valid_cyc > 0 && first_valid_cyc <= 3 * SWEEP + 3), 1);
    end_scenario("t2");

    // 3: bouncing contacts then (0,3) stable
    exact = 0;
    do_reset();
    run_sweep(16'h0000, 0, 1);
    for (int k = 0; k < 4; k++) run_sweep(16'h0008, 0, 0);
    for (int k = 0; k < 3; k++) run_sweep(16'h0000, 0, 0);
    exp_q.push_back(3);
    end_scenario("t3");
    exact = 1;

    // 4: two keys in one row never report
    do_reset();
    for (int k = 0; k < 5; k++) run_sweep(16'h0050, 0, 0);
    run_sweep(16'h0000, 0, 0);
    end_scenario("t4");
    chk("t4_never_valid", first_valid_cyc, 32'hFFFF_FFFF);

    // 5a: unacked (0,0) then (3,3) -> overrun, code stays 0
    auto_ack = 0;
    do_reset();
    run_sweep(16'h0001, 0, 0); run_sweep(16'h0001, 0, 0);
    run_sweep(16'h0000, 0, 0); run_sweep(16'h0000, 0, 0);
    run_sweep(16'h8000, 0, 0); run_sweep(16'h8000, 0, 0);
    run_sweep(16'h0000, 0, 0); run_sweep(16'h0000, 0, 0);
    end_scenario("t5a");
    chk("t5a_ovr", obs_ovr, 1);
    chk("t5a_code", kif.key_code, 4'h0);

    // 5b: ack on the accept edge -> new code, no overrun
    do_reset();
    run_sweep(16'h0001, 0, 0); run_sweep(16'h0001, 0, 0);
    run_sweep(16'h0000, 0, 0); run_sweep(16'h0000, 0, 0);
    run_sweep(16'h8000, 0, 0); run_sweep(16'h8000, 0, 0);
    run_sweep(16'h0000, 1, 0); run_sweep(16'h0000, 0, 0);
    end_scenario("t5b");
    chk("t5b_code", kif.key_code, 4'hF);
    chk("t5b_valid", kif.key_valid, 1'b1);
    chk("t5b_ovr", obs_ovr, 0);

    // 6: asynchronous reset mid-sweep with an event pending
    do_reset();
    run_sweep(16'h0001, 0, 0); run_sweep(16'h0001, 0, 0);
    keys = '0;
    repeat (6) @(posedge clk);
    #3;
    chk("t6_pre_valid", kif.key_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", kif.key_valid, 1'b0);
    chk("t6_async_col", col, 4'b1110);
    chk("t6_async_code", kif.key_code, 4'h0);

    // Randomized sweep sequences
    for (int s = 0; s < 14; s++) begin
      auto_ack = ($urandom_range(0, 1) == 1);
      do_reset();
      run_left = 0;
      mask     = '0;
      n        = $urandom_range(8, 14);
      for (int k = 0; k < n; k++) begin
        if (run_left == 0) begin
          kind = $urandom_range(0, 3);
          a    = $urandom_range(0, 15);
          b    = (a + $urandom_range(1, 15)) % 16;
          mask = '0;
          if (kind == 1 || kind == 2) mask[a] = 1'b1;
          if (kind == 3) begin mask[a] = 1'b1; mask[b] = 1'b1; end
          run_left = $urandom_range(1, 3);
        end
        af = !auto_ack && ($urandom_range(0, 3) == 0);
        run_sweep(mask, af, 0);
        run_left--;
      end
      run_sweep(16'h0000, 0, 0);
      end_scenario("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
